vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side reader for the dual-port framebuffer memory; drives the read-only VGA port (addrb in, doutb out, 1-cycle registered read).
- Generates 640x480 VGA timing from the system clock using an internal pixel-clock divider.
- Scales a low-resolution byte-per-pixel framebuffer up to the screen, aligns the read data with the sync signals, and outputs pixels plus vblank and frame-start indications for the z80 side.

Parameters:
- H_ACTIVE 640, visible pixels per line
- H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync widths, in pixels
- V_ACTIVE 480, visible lines
- V_FP 10, V_SYNC 2, V_BP 33: vertical porch and sync widths, in lines
- CLK_DIV 4, system clocks per pixel
- SCALE_SHIFT 2, log2 of the scale factor; source is (H_ACTIVE>>S) x (V_ACTIVE>>S) = 160x120
- ADDR 16, memory address width
- DATA 8, pixel width (RGB332)

Ports:
- clk, in, 1: system clock (100MHz)
- rst_L, in, 1: asynchronous active-low reset
- fb_base, in, ADDR: framebuffer base address, sampled once per frame
- addrb, out, ADDR: read address to the memory VGA port
- doutb, in, DATA: read data, valid the cycle after addrb is sampled
- hsync_L, out, 1: horizontal sync, active low
- vsync_L, out, 1: vertical sync, active low
- de, out, 1: display enable, high while a visible pixel is output
- rgb, out, DATA: pixel value; 0 when de=0
- vblank, out, 1: high while the vertical position is at or beyond V_ACTIVE
- frame_start, out, 1: one-clock pulse at the start of each frame

Behaviour:
- Totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Divider div counts 0..CLK_DIV-1 and wraps to 0. tick = (div == CLK_DIV-1).
- Position counters h, v advance only on tick:
  - h = H_TOTAL-1 wraps h to 0 and increments v.
  - v = V_TOTAL-1 with h wrapping wraps v to 0.
- base_q latches fb_base on the tick that moves the counters to (0,0). Changes to fb_base mid-frame take effect only at the next frame; there is no tearing.
- Stage 0 (combinational from h, v, base_q):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs is the same window applied to v with the V parameters
  - vb = v >= V_ACTIVE
  - fs = (h==0 && v==0 && div==0)
  - addrb = base_q + (v>>S)*(H_ACTIVE>>S) + (h>>S), truncated mod 2^ADDR, when active; addrb = base_q otherwise.
- Stage 1 registers hs, vs, vb, active and fs on every clk. This aligns them with doutb.
- Stage 2 registers the outputs on every clk:
  - hsync_L = ~hs_d1, vsync_L = ~vs_d1
  - de = active_d1, vblank = vb_d1, frame_start = fs_d1
  - rgb = active_d1 ? doutb : 0
- Latency: every output reflects the counter state from exactly 2 clocks earlier. All outputs are mutually aligned.
- Reset (asynchronous, any time including mid-line or mid-frame):
  - div = h = v = 0, base_q = 0, all pipeline registers cleared.
  - Outputs: hsync_L=1, vsync_L=1, de=0, rgb=0, vblank=0, frame_start=0. addrb=0 while rst_L is low.
- After release, timing restarts from (0,0). The first frame_start pulse appears 2 clocks after release, and that frame reads from base 0.
- The memory is never written by this block; there is no back-pressure.

Test Plan:
- Reset release, then run one frame -> frame_start pulses at clock 2 and again at clock 2+1,680,000. There are no other pulses in between.
- Line 0 sync -> hsync_L falls 2+656*4=2626 clocks after release and stays low for exactly 384 clocks. de is high for 2560 clocks, from clock 2 to clock 2561.
- Address mapping with fb_base=0x1000 held from before a frame -> at (h=4,v=4) addrb=0x1000+161. At (639,479) addrb=0x1000+19199. During blanking addrb=0x1000.
- Memory model preloaded with mem[a]=a[7:0] -> rgb equals the low byte of the address issued 2 clocks earlier when de=1. rgb=0 whenever de=0.
- fb_base changed from 0x0000 to 0x5000 at line 100 -> the rest of the current frame still reads base 0x0000. The next frame's first address is 0x5000.
- Vertical -> vblank rises at line 480 and vsync_L is low during lines 490-491. rst_L pulsed low mid-line 200 -> outputs reset immediately and timing restarts at (0,0).

Source files
------------

// File: rtl/vga_scanout.sv
// 640x480 VGA scanout: pixel-clock divider, h/v timing, scaled framebuffer addressing,
// and a two-stage pipeline that aligns sync/enable with the registered memory read data.
module vga_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned ADDR        = 16,
    parameter int unsigned DATA        = 8
) (
    input  logic            clk,
    input  logic            rst_L,
    input  logic [ADDR-1:0] fb_base,
    output logic [ADDR-1:0] addrb,
    input  logic [DATA-1:0] doutb,
    output logic            hsync_L,
    output logic            vsync_L,
    output logic            de,
    output logic [DATA-1:0] rgb,
    output logic            vblank,
    output logic            frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]   H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]   V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]   H_ACT_C   = HW'(H_ACTIVE);
    localparam logic [HW-1:0]   HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]   HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]   V_ACT_C   = VW'(V_ACTIVE);
    localparam logic [VW-1:0]   VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]   VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR-1:0] SRC_WIDTH = ADDR'(H_ACTIVE >> SCALE_SHIFT);

    logic [DW-1:0]   r_div;
    logic [HW-1:0]   r_h;
    logic [VW-1:0]   r_v;
    logic [ADDR-1:0] r_base;

    logic            w_tick;
    logic            w_h_last;
    logic            w_v_last;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);

    // The base is captured only on the wrap to (0,0) so a frame never mixes two buffers.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_div  <= '0;
            r_h    <= '0;
            r_v    <= '0;
            r_base <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (w_h_last) begin
                r_h <= '0;
                if (w_v_last) begin
                    r_v    <= '0;
                    r_base <= fb_base;
                end else begin
                    r_v <= r_v + VW'(1);
                end
            end else begin
                r_h <= r_h + HW'(1);
            end
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    logic            w_active;
    logic            w_hs;
    logic            w_vs;
    logic            w_vb;
    logic            w_fs;
    logic [ADDR-1:0] w_row;
    logic [ADDR-1:0] w_col;

    assign w_active = (r_h < H_ACT_C) && (r_v < V_ACT_C);
    assign w_hs     = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs     = (r_v >= VS_START) && (r_v < VS_END);
    assign w_vb     = (r_v >= V_ACT_C);
    assign w_fs     = (r_h == '0) && (r_v == '0) && (r_div == '0);
    assign w_row    = ADDR'(r_v >> SCALE_SHIFT);
    assign w_col    = ADDR'(r_h >> SCALE_SHIFT);
    assign addrb    = w_active ? (r_base + (w_row * SRC_WIDTH) + w_col) : r_base;

    // Stage 1 lines the control bits up with doutb, which lags addrb by one clock.
    logic r_hs_d1;
    logic r_vs_d1;
    logic r_vb_d1;
    logic r_active_d1;
    logic r_fs_d1;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_hs_d1     <= 1'b0;
            r_vs_d1     <= 1'b0;
            r_vb_d1     <= 1'b0;
            r_active_d1 <= 1'b0;
            r_fs_d1     <= 1'b0;
        end else begin
            r_hs_d1     <= w_hs;
            r_vs_d1     <= w_vs;
            r_vb_d1     <= w_vb;
            r_active_d1 <= w_active;
            r_fs_d1     <= w_fs;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            hsync_L     <= 1'b1;
            vsync_L     <= 1'b1;
            de          <= 1'b0;
            rgb         <= '0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync_L     <= ~r_hs_d1;
            vsync_L     <= ~r_vs_d1;
            de          <= r_active_d1;
            rgb         <= r_active_d1 ? doutb : '0;
            vblank      <= r_vb_d1;
            frame_start <= r_fs_d1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-timing instance checked cycle by cycle through a scoreboard,
// and a full 640x480 instance checked against hand-computed line-0 timing.
module tb_vga_scanout;

    // Small timing: 24 clocks-of-pixels per line, 13 lines, 2 clocks per pixel, 2x scale.
    localparam int SHA = 16, SHFP = 2, SHS = 3, SHB = 3;
    localparam int SVA = 8, SVFP = 1, SVS = 2, SVB = 2;
    localparam int SCD = 2;
    localparam int SHT = SHA + SHFP + SHS + SHB;
    localparam int SVT = SVA + SVFP + SVS + SVB;

    typedef struct packed {
        logic       hs_l;
        logic       vs_l;
        logic       de;
        logic       vb;
        logic       fs;
        logic [7:0] rgb;
    } exp_t;

    localparam exp_t RST_OUT = '{hs_l: 1'b1, vs_l: 1'b1, de: 1'b0, vb: 1'b0, fs: 1'b0, rgb: 8'h00};

    logic        clk;
    logic        rst_L;

    logic [15:0] fb_s, addrb_s;
    logic [7:0]  doutb_s, rgb_s;
    logic        hs_s, vs_s, de_s, vb_s, fs_s;

    logic [15:0] fb_f, addrb_f;
    logic [7:0]  doutb_f, rgb_f;
    logic        hs_f, vs_f, de_f, vb_f, fs_f;

    vga_scanout #(
        .H_ACTIVE(SHA), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVB),
        .CLK_DIV(SCD), .SCALE_SHIFT(1), .ADDR(16), .DATA(8)
    ) u_small (
        .clk(clk), .rst_L(rst_L), .fb_base(fb_s), .addrb(addrb_s), .doutb(doutb_s),
        .hsync_L(hs_s), .vsync_L(vs_s), .de(de_s), .rgb(rgb_s), .vblank(vb_s),
        .frame_start(fs_s)
    );

    vga_scanout u_full (
        .clk(clk), .rst_L(rst_L), .fb_base(fb_f), .addrb(addrb_f), .doutb(doutb_f),
        .hsync_L(hs_f), .vsync_L(vs_f), .de(de_f), .rgb(rgb_f), .vblank(vb_f),
        .frame_start(fs_f)
    );

    // Memories preloaded with mem[a] = a[7:0], one-clock registered read.
    always @(posedge clk) begin
        doutb_s <= addrb_s[7:0];
        doutb_f <= addrb_f[7:0];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference model of the small instance.
    int          m_div, m_h, m_v, cyc;
    logic [15:0] m_base, m_addr;
    logic        run = 1'b0;
    exp_t        sb[$];
    int          fs_cyc[$];

    function automatic logic [15:0] model_addr(input int h, input int v, input logic [15:0] b);
        if (h < SHA && v < SVA) return b + 16'((v / 2) * (SHA / 2) + (h / 2));
        return b;
    endfunction

    function automatic exp_t model_out(input int h, input int v, input int d,
                                       input logic [15:0] a);
        exp_t e;
        e.hs_l = !(h >= SHA + SHFP && h < SHA + SHFP + SHS);
        e.vs_l = !(v >= SVA + SVFP && v < SVA + SVFP + SVS);
        e.de   = (h < SHA) && (v < SVA);
        e.vb   = (v >= SVA);
        e.fs   = (h == 0) && (v == 0) && (d == 0);
        e.rgb  = e.de ? a[7:0] : 8'h00;
        return e;
    endfunction

    task automatic model_step();
        if (m_div == SCD - 1) begin
            m_div = 0;
            if (m_h == SHT - 1) begin
                m_h = 0;
                if (m_v == SVT - 1) begin
                    m_v    = 0;
                    m_base = fb_s;
                end else begin
                    m_v++;
                end
            end else begin
                m_h++;
            end
        end else begin
            m_div++;
        end
    endtask

    // Driver: advances the model just after each active edge and queues the expected outputs,
    // which the DUT presents two clocks later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (run) begin
                model_step();
                cyc++;
                m_addr = model_addr(m_h, m_v, m_base);
                sb.push_back(model_out(m_h, m_v, m_div, m_addr));
            end
        end
    end

    logic [15:0] a44, a_last, a00;

    // Monitor for the small instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_L) begin
                chk("rst_addrb", addrb_s, 0);
                chk("rst_hsync_L", hs_s, RST_OUT.hs_l);
                chk("rst_vsync_L", vs_s, RST_OUT.vs_l);
                chk("rst_de", de_s, RST_OUT.de);
                chk("rst_vblank", vb_s, RST_OUT.vb);
                chk("rst_frame_start", fs_s, RST_OUT.fs);
                chk("rst_rgb", rgb_s, RST_OUT.rgb);
            end else if (run) begin
                chk("addrb", addrb_s, m_addr);
                if (m_h == 4 && m_v == 4 && m_div == 0) a44 = addrb_s;
                if (m_h == SHA - 1 && m_v == SVA - 1 && m_div == 0) a_last = addrb_s;
                if (m_h == 0 && m_v == 0 && m_div == 0) a00 = addrb_s;
                if (fs_s) fs_cyc.push_back(cyc);
                chk("sb_depth", sb.size(), 3);
                if (sb.size() >= 3) begin
                    e = sb.pop_front();
                    chk("hsync_L", hs_s, e.hs_l);
                    chk("vsync_L", vs_s, e.vs_l);
                    chk("de", de_s, e.de);
                    chk("vblank", vb_s, e.vb);
                    chk("frame_start", fs_s, e.fs);
                    chk("rgb", rgb_s, e.rgb);
                end
            end
        end
    end

    // Measurements on the full-size instance during the first epoch.
    logic full_on = 1'b0;
    logic hs_prev = 1'b1;
    int   f_fall = -1, f_rise = -1, de_cnt = 0, de_first = -1, de_last = -1;
    int   f_fs_cnt = 0, f_fs_at = -1, f_vbad = 0;
    logic [15:0] f_addr44 = 16'hffff, f_addr_blank = 16'hffff;
    logic [7:0]  f_rgb44 = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (full_on && rst_L && run) begin
                if (!hs_f && hs_prev && f_fall < 0) f_fall = cyc;
                if (hs_f && !hs_prev && f_fall >= 0 && f_rise < 0) f_rise = cyc;
                hs_prev = hs_f;
                if (de_f && cyc < 3200) begin
                    de_cnt++;
                    if (de_first < 0) de_first = cyc;
                    de_last = cyc;
                end
                if (cyc == 2600) f_addr_blank = addrb_f;
                if (cyc == 12816) f_addr44 = addrb_f;
                if (cyc == 12818) f_rgb44 = rgb_f;
                if (fs_f) begin
                    f_fs_cnt++;
                    f_fs_at = cyc;
                end
                if (!vs_f || vb_f) f_vbad++;
            end
        end
    end

    // Releases reset between edges and seeds the scoreboard with the two reset-valued
    // outputs that precede the first real one.
    task automatic release_reset();
        @(posedge clk);
        #2;
        cyc    = 0;
        m_div  = 0;
        m_h    = 0;
        m_v    = 0;
        m_base = 16'h0000;
        m_addr = model_addr(0, 0, 16'h0000);
        sb.delete();
        sb.push_back(RST_OUT);
        sb.push_back(RST_OUT);
        sb.push_back(model_out(0, 0, 0, m_addr));
        fs_cyc.delete();
        rst_L = 1'b1;
        run   = 1'b1;
    endtask

    task automatic wait_state(input int v, input int h, input logic [15:0] b, input string nm);
        bit hit = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #2;
            if (m_v == v && m_h == h && m_div == 0 && m_base == b) begin
                hit = 1;
                break;
            end
        end
        if (!hit) chk(nm, 0, 1);
    endtask

    initial begin
        rst_L = 1'b0;
        fb_s  = 16'h0000;
        fb_f  = 16'h1000;
        repeat (3) @(posedge clk);
        full_on = 1'b1;
        release_reset();
        repeat (13005) @(posedge clk);
        full_on = 1'b0;

        chk("full_hsync_fall", f_fall, 2626);
        chk("full_hsync_width", f_rise - f_fall, 384);
        chk("full_de_first", de_first, 2);
        chk("full_de_last", de_last, 2561);
        chk("full_de_count", de_cnt, 2560);
        chk("full_addr_blank", f_addr_blank, 16'h0000);
        chk("full_addr_4_4", f_addr44, 161);
        chk("full_rgb_4_4", f_rgb44, 8'hA1);
        chk("full_fs_count", f_fs_cnt, 1);
        chk("full_fs_at", f_fs_at, 2);
        chk("full_no_vblank_vsync", f_vbad, 0);

        // Small instance: switch to 0x1000, then to 0x5000 at line 4 of a 0x1000 frame.
        #1 fb_s = 16'h1000;
        wait_state(4, 0, 16'h1000, "wait_line4");
        #1 fb_s = 16'h5000;
        wait_state(SVA, 0, 16'h1000, "wait_vblank");
        chk("addr_4_4_old_base", a44, 16'h1012);
        chk("addr_last_old_base", a_last, 16'h101F);
        wait_state(1, 0, 16'h5000, "wait_new_frame");
        chk("addr_0_0_new_base", a00, 16'h5000);

        // Asynchronous reset mid-line, between clock edges.
        wait_state(5, 5, 16'h5000, "wait_midline");
        #1;
        run   = 1'b0;
        rst_L = 1'b0;
        repeat (3) @(posedge clk);
        release_reset();
        repeat (900) @(posedge clk);
        chk("fs_pulse_count", fs_cyc.size(), 2);
        if (fs_cyc.size() >= 2) begin
            chk("fs_first", fs_cyc[0], 2);
            chk("fs_second", fs_cyc[1], 2 + SHT * SVT * SCD);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
